// File: rtl/seq_divider_pkg.sv
// Shared types for the operator block: mode select and divider FSM.
// Existing opr_mode_t encodings stay fixed; DIV is appended.
package seq_divider_pkg;

  localparam int DEF_BITS = 16;

  typedef enum logic [1:0] {
    OPR_ADD,
    OPR_SUB,
    OPR_MUL,
    OPR_DIV
  } opr_mode_t;

  typedef enum logic {
    IDLE,
    RUN
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// start/busy/done handshake plus packed operand and result lanes.
// SW = {RH, LH}; LED = {remainder, quotient}.
interface seq_divider_if #(
  parameter int BITS = 16
) ();

  logic            start;
  logic [BITS-1:0] SW;
  logic            busy;
  logic            done;
  logic            div0;
  logic [BITS-1:0] LED;

  modport master (
    output start,
    output SW,
    input  busy,
    input  done,
    input  div0,
    input  LED
  );

  modport slave (
    input  start,
    input  SW,
    output busy,
    output done,
    output div0,
    output LED
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift in a dividend bit, trial subtract.
// Compare is H+1 bits wide; the difference always fits in H bits.
module div_step #(
  parameter int H = 8
) (
  input  logic [H-1:0] rem_in,
  input  logic         bit_in,
  input  logic [H-1:0] divisor,
  output logic [H-1:0] rem_out,
  output logic         q_bit
);

  logic [H:0] wide;

  assign wide    = {rem_in, bit_in};
  assign q_bit   = (wide >= {1'b0, divisor});
  assign rem_out = q_bit ? (wide[H-1:0] - divisor)
                         : wide[H-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, H steps per operation.
// Result lanes: LED = {LH % RH, LH / RH}; RH == 0 flags div0.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input logic        clk,
  input logic        rst,
  seq_divider_if.slave bus
);

  localparam int H  = BITS / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  div_state_t      state_q;
  logic [CW-1:0]   count_q;
  logic [H-1:0]    lh_q;
  logic [H-1:0]    rh_q;
  logic [H-1:0]    rem_q;
  logic [H-1:0]    dvd_q;
  logic [H-1:0]    quo_q;
  logic            busy_q;
  logic            done_q;
  logic            div0_q;
  logic [BITS-1:0] led_q;

  logic [H-1:0]    rem_d;
  logic [H-1:0]    quo_d;
  logic            q_bit;

  div_step #(.H(H)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[H-1]),
    .divisor (rh_q),
    .rem_out (rem_d),
    .q_bit   (q_bit)
  );

  assign quo_d = {quo_q[H-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      lh_q    <= '0;
      rh_q    <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            lh_q    <= bus.SW[H-1:0];
            rh_q    <= bus.SW[BITS-1:H];
            dvd_q   <= bus.SW[H-1:0];
            rem_q   <= '0;
            quo_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q   <= rem_d;
          dvd_q   <= {dvd_q[H-2:0], 1'b0};
          quo_q   <= quo_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
            div0_q  <= (rh_q == '0);
            // divide by zero: all-ones quotient, dividend as remainder
            if (rh_q == '0)
              led_q <= {lh_q, {H{1'b1}}};
            else
              led_q <= {rem_d, quo_d};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.LED  = led_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks for seq_divider (BITS = 16).
// Results sampled 1 time unit after each rising edge.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.BITS(16)) bus ();

  seq_divider #(.BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] sw, output int lat);
    bus.SW    = sw;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.SW    = 16'h07C8;
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b0)
      $display("FAIL rst_busy got=%b want=0", bus.busy);
    else passed++;
    total++;
    if (bus.done !== 1'b0)
      $display("FAIL rst_done got=%b want=0", bus.done);
    else passed++;
    total++;
    if (bus.div0 !== 1'b0)
      $display("FAIL rst_div0 got=%b want=0", bus.div0);
    else passed++;
    total++;
    if (bus.LED !== 16'h0000)
      $display("FAIL rst_led got=%h want=0000", bus.LED);
    else passed++;
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0)
      $display("FAIL rst_wins got=%b want=0", bus.busy);
    else passed++;
  endtask

  task automatic test_basic();
    int lat;
    do_op(16'h07C8, lat);
    total++;
    if (lat !== 8)
      $display("FAIL basic_lat got=%0d want=8", lat);
    else passed++;
    total++;
    if (bus.LED !== 16'h041C)
      $display("FAIL basic_led got=%h want=041c", bus.LED);
    else passed++;
    total++;
    if (bus.div0 !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL basic_flags got=%b%b want=00",
               bus.div0, bus.busy);
    else passed++;
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.LED !== 16'h041C)
      $display("FAIL basic_hold got=%b/%h want=0/041c",
               bus.done, bus.LED);
    else passed++;
  endtask

  task automatic test_div0();
    int lat;
    do_op(16'h0055, lat);
    total++;
    if (lat !== 8 || bus.LED !== 16'h55FF || bus.div0 !== 1'b1)
      $display("FAIL div0 got=%0d/%h/%b want=8/55ff/1",
               lat, bus.LED, bus.div0);
    else passed++;
    do_op(16'h0203, lat);
    total++;
    if (lat !== 8 || bus.LED !== 16'h0101 || bus.div0 !== 1'b0)
      $display("FAIL after_div0 got=%0d/%h/%b want=8/0101/0",
               lat, bus.LED, bus.div0);
    else passed++;
  endtask

  task automatic test_edges();
    logic [15:0] sw [3];
    logic [15:0] ex [3];
    int lat;
    sw[0] = 16'h01FF; ex[0] = 16'h00FF;
    sw[1] = 16'h0905; ex[1] = 16'h0500;
    sw[2] = 16'hFFFF; ex[2] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      do_op(sw[i], lat);
      total++;
      if (lat !== 8 || bus.LED !== ex[i] || bus.div0 !== 1'b0)
        $display("FAIL edge_%0d got=%0d/%h want=8/%h",
                 i, lat, bus.LED, ex[i]);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int n = 0;
    int first = -1;
    bus.SW    = 16'h07C8;
    bus.start = 1'b1;
    tick();
    bus.SW    = 16'h0203;
    for (int c = 1; c <= 20; c++) begin
      bus.start = (c >= 2 && c <= 7);
      tick();
      if (bus.done === 1'b1) begin
        n++;
        if (first < 0) first = c;
      end
    end
    bus.start = 1'b0;
    total++;
    if (n !== 1 || first !== 8)
      $display("FAIL ignore_start got=%0d@%0d want=1@8",
               n, first);
    else passed++;
    total++;
    if (bus.LED !== 16'h041C)
      $display("FAIL ignore_sw got=%h want=041c", bus.LED);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int d1 = -1;
    int d2 = -1;
    logic [15:0] led1 = '0;
    logic b9 = 1'b0;
    bus.SW    = 16'h0203;
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 22; c++) begin
      bus.start = (c <= 9);
      if (c == 9) bus.SW = 16'h0905;
      tick();
      if (c == 9) b9 = bus.busy;
      if (bus.done === 1'b1) begin
        n++;
        if (d1 < 0) begin
          d1 = c;
          led1 = bus.LED;
        end else d2 = c;
      end
    end
    bus.start = 1'b0;
    total++;
    if (n !== 2 || d1 !== 8 || d2 !== 17)
      $display("FAIL b2b_done got=%0d@%0d,%0d want=2@8,17",
               n, d1, d2);
    else passed++;
    total++;
    if (b9 !== 1'b1)
      $display("FAIL b2b_busy got=%b want=1", b9);
    else passed++;
    total++;
    if (led1 !== 16'h0101 || bus.LED !== 16'h0500)
      $display("FAIL b2b_led got=%h,%h want=0101,0500",
               led1, bus.LED);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int n = 0;
    do_op(16'h0055, lat);
    bus.SW    = 16'h07C8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.LED !== 16'h0000 || bus.div0 !== 1'b0)
      $display("FAIL mid_rst got=%b%b/%h/%b want=00/0000/0",
               bus.busy, bus.done, bus.LED, bus.div0);
    else passed++;
    repeat (12) begin
      tick();
      if (bus.done === 1'b1) n++;
    end
    total++;
    if (n !== 0)
      $display("FAIL mid_rst_nodone got=%0d want=0", n);
    else passed++;
    do_op(16'h0905, lat);
    total++;
    if (lat !== 8 || bus.LED !== 16'h0500)
      $display("FAIL mid_rst_fresh got=%0d/%h want=8/0500",
               lat, bus.LED);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] sw;
    logic [7:0]  lh;
    logic [7:0]  rh;
    logic [15:0] ex;
    logic        ez;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      sw = 16'($urandom_range(0, 16'hFFFF));
      lh = sw[7:0];
      rh = sw[15:8];
      if (rh == 8'd0) begin
        ex = {lh, 8'hFF};
        ez = 1'b1;
      end else begin
        ex = {8'(lh % rh), 8'(lh / rh)};
        ez = 1'b0;
      end
      do_op(sw, lat);
      total++;
      if (lat !== 8 || bus.LED !== ex || bus.div0 !== ez)
        $display("FAIL rand sw=%h got=%0d/%h/%b want=8/%h/%b",
                 sw, lat, bus.LED, bus.div0, ex, ez);
      else passed++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.SW    = '0;
    rst       = 1'b1;
    test_reset();
    test_basic();
    test_div0();
    test_edges();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
